// File: rtl/m_load_counter_pkg.sv
// Shared definitions for the counter section: run-control state encoding
// and the default counter width.
package m_load_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cnt_state_t;

   localparam int CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/m_load_counter_adder1.sv
// Half-adder cell: one bit of the increment ripple chain.
module m_ADDER1 (
   input  logic a,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ ci;
   assign co = a & ci;

endmodule

// File: rtl/m_load_counter.sv
// Loadable, limit-terminated up-counter with IDLE/RUN/DONE run control,
// terminal-count pulse, auto-reload and sticky overflow flag.
module m_load_counter
   import m_load_counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             GO,
   input  logic             INC,
   input  logic             AUTO,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             CO,
   output logic             BUSY
);

   cnt_state_t       state;
   cnt_state_t       state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic             co_nxt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   logic             at_limit;
   logic             terminal;
   logic             inc_en;

   assign at_limit = (Q == LIMIT);
   assign terminal = (state == RUN) && INC && !LD && at_limit;
   // The chain only ever sees a carry-in when a genuine increment is taken,
   // so its top carry-out is the wrap indication for that cycle alone.
   assign inc_en   = (state == RUN) && INC && !LD && !at_limit;

   assign carry[0] = inc_en;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_chain
         m_ADDER1 u_bit (
            .a  (Q[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
         );
      end
   endgenerate

   // Next-state and next-output selection: LD > terminal > increment > hold.
   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      co_nxt    = CO;
      tc_nxt    = 1'b0;
      if (LD) begin
         q_nxt  = D;
         co_nxt = 1'b0;
         if (GO)
            state_nxt = RUN;
         else if (state == DONE)
            state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (GO) state_nxt = RUN;
            RUN: begin
               if (terminal) begin
                  tc_nxt = 1'b1;
                  if (AUTO)
                     q_nxt = D;
                  else
                     state_nxt = DONE;
               end else if (inc_en) begin
                  q_nxt = sum;
                  if (carry[WIDTH])
                     co_nxt = 1'b1;
               end
            end
            DONE: if (GO) state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // All outputs are registered alongside the state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q    <= '0;
         TC   <= 1'b0;
         CO   <= 1'b0;
         BUSY <= 1'b0;
      end else begin
         Q    <= q_nxt;
         TC   <= tc_nxt;
         CO   <= co_nxt;
         BUSY <= (state_nxt == RUN);
      end
   end

endmodule

// File: tb/tb_m_load_counter.sv
// Directed bench for m_load_counter: behavioural model compared every cycle,
// plus literal expectations at key points of each scenario.
module tb_m_load_counter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       LD = 1'b0;
   logic [7:0] D = 8'h00;
   logic [7:0] LIMIT = 8'h00;
   logic       GO = 1'b0;
   logic       INC = 1'b0;
   logic       AUTO = 1'b0;
   logic [7:0] Q;
   logic       TC;
   logic       CO;
   logic       BUSY;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // model state: 0 idle, 1 run, 2 done
   int mq = 0;
   int mst = 0;
   bit mtc = 1'b0;
   bit mco = 1'b0;

   m_load_counter #(.WIDTH(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .LD    (LD),
      .D     (D),
      .LIMIT (LIMIT),
      .GO    (GO),
      .INC   (INC),
      .AUTO  (AUTO),
      .Q     (Q),
      .TC    (TC),
      .CO    (CO),
      .BUSY  (BUSY)
   );

   always #5 CLK = ~CLK;

   // Behavioural model of the counter rules, updated on each rising edge.
   always @(posedge CLK) begin
      if (RESET) begin
         mq = 0; mst = 0; mtc = 1'b0; mco = 1'b0;
      end else begin
         mtc = 1'b0;
         if (LD) begin
            mq  = int'(D);
            mco = 1'b0;
            if (GO) mst = 1;
            else if (mst == 2) mst = 0;
         end else if (mst == 0) begin
            if (GO) mst = 1;
         end else if (mst == 1) begin
            if (INC) begin
               if (mq == int'(LIMIT)) begin
                  mtc = 1'b1;
                  if (AUTO) mq = int'(D);
                  else mst = 2;
               end else if (mq == 255) begin
                  mq  = 0;
                  mco = 1'b1;
               end else begin
                  mq = mq + 1;
               end
            end
         end else begin
            if (GO) mst = 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (checking) begin
         checks += 4;
         if (int'(Q) != mq) begin
            errors++;
            $display("[TB] FAIL model_q t=%0t got %0h expected %0h", $time, Q, mq);
         end
         if (TC !== mtc) begin
            errors++;
            $display("[TB] FAIL model_tc t=%0t got %0b expected %0b", $time, TC, mtc);
         end
         if (CO !== mco) begin
            errors++;
            $display("[TB] FAIL model_co t=%0t got %0b expected %0b", $time, CO, mco);
         end
         if (BUSY !== (mst == 1)) begin
            errors++;
            $display("[TB] FAIL model_busy t=%0t got %0b expected %0b", $time, BUSY, (mst == 1));
         end
      end
   end

   task automatic applyStimulus(input bit ld, input logic [7:0] d, input logic [7:0] limit,
                                input bit go, input bit inc, input bit auto, input int cycles);
      LD = ld; D = d; LIMIT = limit; GO = go; INC = inc; AUTO = auto;
      repeat (cycles) @(negedge CLK);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] eq, input bit etc,
                              input bit eco, input bit ebusy);
      checks++;
      if (Q !== eq || TC !== etc || CO !== eco || BUSY !== ebusy) begin
         errors++;
         $display("[TB] FAIL %s got Q=%0h TC=%0b CO=%0b BUSY=%0b expected Q=%0h TC=%0b CO=%0b BUSY=%0b",
                  name, Q, TC, CO, BUSY, eq, etc, eco, ebusy);
      end
   endtask

   logic [7:0] autoQ [6] = '{8'h03, 8'h04, 8'h02, 8'h03, 8'h04, 8'h02};
   bit         autoTc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      // reset with random inputs
      @(negedge CLK);
      RESET = 1'b1;
      repeat (2) begin
         LD = 1'($urandom); D = 8'($urandom); LIMIT = 8'($urandom);
         GO = 1'($urandom); INC = 1'($urandom); AUTO = 1'($urandom);
         @(negedge CLK);
      end
      checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      RESET = 1'b0;
      applyStimulus(0, 8'h00, 8'hFF, 0, 0, 0, 1);
      checking = 1'b1;
      applyStimulus(0, 8'h00, 8'hFF, 1, 0, 0, 1);
      checkOutput("go_busy", 8'h00, 1'b0, 1'b0, 1'b1);

      // count to stop
      applyStimulus(1, 8'h05, 8'h08, 0, 0, 0, 1);
      checkOutput("stop_load", 8'h05, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 8'h05, 8'h08, 0, 1, 0, 1);
      checkOutput("stop_q06", 8'h06, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 8'h05, 8'h08, 0, 1, 0, 2);
      checkOutput("stop_q08", 8'h08, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 8'h05, 8'h08, 0, 1, 0, 1);
      checkOutput("stop_tc", 8'h08, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 8'h05, 8'h08, 0, 1, 0, 1);
      checkOutput("stop_hold", 8'h08, 1'b0, 1'b0, 1'b0);

      // restart from DONE: immediate terminal
      applyStimulus(0, 8'h05, 8'h08, 1, 1, 0, 1);
      checkOutput("restart_run", 8'h08, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 8'h05, 8'h08, 0, 1, 0, 1);
      checkOutput("restart_tc", 8'h08, 1'b1, 1'b0, 1'b0);

      // auto-reload
      applyStimulus(1, 8'h02, 8'h04, 1, 0, 1, 1);
      checkOutput("auto_load", 8'h02, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 8'h02, 8'h04, 0, 1, 1, 1);
         checkOutput($sformatf("auto_step%0d", i), autoQ[i], autoTc[i], 1'b0, 1'b1);
      end

      // D == LIMIT with AUTO: TC continuous
      applyStimulus(1, 8'h04, 8'h04, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 8'h04, 8'h04, 0, 1, 1, 1);
         checkOutput($sformatf("tc_cont%0d", i), 8'h04, 1'b1, 1'b0, 1'b1);
      end

      // overflow
      applyStimulus(1, 8'hFE, 8'h10, 1, 0, 0, 1);
      applyStimulus(0, 8'hFE, 8'h10, 0, 1, 0, 1);
      checkOutput("ovf_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 8'hFE, 8'h10, 0, 1, 0, 1);
      checkOutput("ovf_00", 8'h00, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 8'hFE, 8'h10, 0, 1, 0, 1);
      checkOutput("ovf_01", 8'h01, 1'b0, 1'b1, 1'b1);
      applyStimulus(1, 8'h20, 8'h10, 0, 0, 0, 1);
      checkOutput("ovf_clear", 8'h20, 1'b0, 1'b0, 1'b1);

      // priority: LD beats terminal in RUN, LD+GO from DONE
      applyStimulus(1, 8'h30, 8'h30, 0, 0, 0, 1);
      applyStimulus(1, 8'h11, 8'h30, 0, 1, 0, 1);
      checkOutput("prio_run", 8'h11, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 8'h30, 8'h30, 0, 0, 0, 1);
      applyStimulus(0, 8'h30, 8'h30, 0, 1, 0, 1);
      checkOutput("prio_done", 8'h30, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 8'h11, 8'h30, 1, 0, 0, 1);
      checkOutput("prio_ldgo", 8'h11, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 8'h30, 8'h30, 0, 0, 0, 1);
      applyStimulus(0, 8'h30, 8'h30, 0, 1, 0, 1);
      applyStimulus(1, 8'h05, 8'h30, 0, 0, 0, 1);
      checkOutput("ld_done_idle", 8'h05, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 8'h05, 8'h30, 0, 1, 0, 2);
      checkOutput("idle_inc", 8'h05, 1'b0, 1'b0, 1'b0);

      // Q already past LIMIT: counts through wrap
      applyStimulus(1, 8'hFD, 8'h01, 1, 0, 0, 1);
      applyStimulus(0, 8'hFD, 8'h01, 0, 1, 0, 4);
      checkOutput("past_wrap", 8'h01, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 8'hFD, 8'h01, 0, 1, 0, 1);
      checkOutput("past_tc", 8'h01, 1'b1, 1'b1, 1'b0);

      // reset mid-run
      applyStimulus(1, 8'h40, 8'h80, 1, 0, 0, 1);
      RESET = 1'b1;
      applyStimulus(0, 8'h40, 8'h80, 0, 1, 0, 1);
      RESET = 1'b0;
      checkOutput("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 8'h40, 8'h80, 0, 1, 0, 2);
      checkOutput("rst_idle_inc", 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 8'h40, 8'h80, 1, 0, 0, 1);
      applyStimulus(0, 8'h40, 8'h80, 0, 1, 0, 1);
      checkOutput("rst_rego", 8'h01, 1'b0, 1'b0, 1'b1);

      applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 2);
      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_load_counter.md
# m_load_counter

Loadable, limit-terminated up-counter for the counter section. It consumes the half-adder cell: each bit's next value and carry-to-next come from a WIDTH-long ripple chain of `m_ADDER1` instances, with the carry-in at bit 0 as the count enable. A small run-control FSM (IDLE/RUN/DONE) sits around the chain, plus terminal-count, auto-reload and sticky-overflow logic. It serves as the step/length counter for sequencers and address generators.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- CLK  in  1  single clock; all state changes on rising edge
- RESET  in  1  reset; synchronous, active-high
- LD  in  1  load Q from D
- D  in  WIDTH  load/reload value
- LIMIT  in  WIDTH  terminal value, sampled every cycle
- GO  in  1  start counting
- INC  in  1  count enable; honoured only in RUN
- AUTO  in  1  1 = reload D at terminal and keep running; 0 = stop at terminal
- Q  out  WIDTH  current count, registered
- TC  out  1  one-cycle terminal-count pulse, registered
- CO  out  1  sticky overflow flag, registered
- BUSY  out  1  high while in RUN, registered

## Operation
- Reset, and the state after RESET: state=IDLE, Q=0, TC=0, CO=0, BUSY=0.
- RESET has priority over every other input.
- Increment: Q+1 is formed by the ripple chain, with carry-in at bit 0 tied to the qualified INC.
  - Carry out of the top bit is the wrap indication.
  - Arithmetic is modulo 2^WIDTH.
- FSM states and transitions:
  - IDLE: Q holds; INC ignored. GO → RUN.
  - RUN: INC=1 and Q≠LIMIT → Q=Q+1.
  - RUN: INC=1 and Q==LIMIT → terminal event.
  - RUN: INC=0 → Q holds. GO is ignored in RUN.
  - DONE: Q holds at LIMIT; INC ignored. GO → RUN.
- Terminal event (RUN, INC=1, Q==LIMIT):
  - TC=1 on the next cycle.
  - AUTO=1: Q←D and state stays RUN.
  - AUTO=0: Q holds and state → DONE.
  - A terminal event never sets CO, even when LIMIT is all-ones.
- Overflow (RUN, INC=1, Q all-ones, Q≠LIMIT): Q←0 and CO←1.
  - CO stays set until LD or RESET clears it.
- LD, in any state:
  - Q←D and CO←0.
  - LD overrides INC and the terminal event in the same cycle: no TC and no increment.
  - State: DONE→IDLE; IDLE and RUN are unchanged.
  - LD and GO together: Q←D and state→RUN.
- BUSY = (state==RUN), registered with the state.

## Timing
- Every output is a flop; there is no combinational path from input to output.
- INC sampled at edge n → Q shows the new value after edge n, i.e. a one-cycle latency.
- Terminal event at edge n → TC high for exactly the cycle after edge n.
  - AUTO=1 with INC held high and D==LIMIT: a terminal event occurs every cycle, so TC stays high continuously.
- GO at edge n → BUSY high after edge n; the first INC honoured is at edge n+1.
- Back-to-back: a GO in the cycle where DONE has just been entered restarts counting from LIMIT.
  - The next INC is then an immediate terminal event, because Q==LIMIT.
- LIMIT changing mid-run takes effect on the next compare with no hazard. If Q is already past LIMIT, Q counts through wrap (setting CO) before it reaches LIMIT.
- RESET mid-run aborts on the same edge; TC is not pulsed.

## Structure
- Shared counters package:
  - state enum `cnt_state_t` {IDLE, RUN, DONE}, 2-bit encoding.
  - constant `CNT_WIDTH_DEFAULT=8`.
- Sub-module: reuse `m_ADDER1` as the per-bit cell, instantiated in a generate loop forming the increment chain. No new sub-module.
- Top file contents: FSM, Q/TC/CO/BUSY registers, LIMIT comparator, next-Q mux with priority LD > terminal > increment > hold.

## Test plan
All scenarios use WIDTH=8.
- Reset: drive RESET for 2 cycles with random inputs → Q=0x00, TC=0, CO=0, BUSY=0. GO alone → BUSY=1 on the next cycle.
- Count to stop: LD D=0x05, LIMIT=0x08, AUTO=0, GO, INC held high.
  - Q steps 06,07,08.
  - The next INC gives TC=1 for one cycle and BUSY=0 (DONE), with Q held at 0x08.
  - Further INC leaves Q at 0x08.
- Auto-reload: D=0x02, LIMIT=0x04, AUTO=1, INC held high → Q sequence 02,03,04,02,03,04…, with TC pulsing once per period on each 04→02 step.
- Overflow: LD D=0xFE, LIMIT=0x10, GO, INC ×3 → Q 0xFF, 0x00, 0x01, with CO=1 from the 0x00 cycle. A subsequent LD → CO=0.
- Priority: in RUN with Q==LIMIT=0x30, assert LD (D=0x11) and INC together → Q=0x11, TC=0, still RUN. Repeat in DONE with LD+GO → Q=D, BUSY=1.
- Reset mid-run: RUN with Q=0x40 and INC high, RESET for 1 cycle → Q=0x00, IDLE, TC never asserted, and INC is ignored until GO.
